// File: rtl/fetch_stage.sv
// fetch_stage: IF pipeline stage.
// Owns the fetch PC, drives a combinational instruction ROM, and registers the
// fetched word into IF/ID. Redirects resolved in ID (JR > J > Z) squash the slot
// currently being fetched, costing one bubble. A stall freezes both the PC and
// IF/ID, and it overrides any redirect; the hazard unit re-presents the redirect
// once the stall clears.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          IMEM_AW  = 6
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               Z,
    input  logic               J,
    input  logic               JR,
    input  logic               PC_IFWrite,
    input  logic [31:0]        JumpAddr,
    input  logic [31:0]        JrAddr,
    input  logic [31:0]        BranchAddr,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [31:0]        imem_data,
    output logic [31:0]        PC,
    output logic [31:0]        NextPC_if,
    output logic [31:0]        Instruction_id,
    output logic [31:0]        NextPC_id,
    output logic               IF_flush,
    output logic [31:0]        FetchCount
);

    logic [31:0] next_pc_sel;
    logic [31:0] next_pc_aligned;

    // The ROM is word addressed. Upper PC bits are dropped, so addresses alias
    // modulo the ROM depth.
    assign imem_addr = PC[IMEM_AW+1:2];

    // PC+4 wraps naturally at 32 bits.
    assign NextPC_if = PC + 32'd4;

    // Any redirect resolved in ID squashes the instruction in IF.
    assign IF_flush  = Z | J | JR;

    // Next-PC mux: JR has highest priority, then J, then branch, then sequential.
    always_comb begin
        next_pc_sel = NextPC_if;
        if (JR)
            next_pc_sel = JrAddr;
        else if (J)
            next_pc_sel = JumpAddr;
        else if (Z)
            next_pc_sel = BranchAddr;
    end

    // Targets are forced to word alignment before they are loaded.
    assign next_pc_aligned = next_pc_sel & 32'hFFFF_FFFC;

    // Update PC and IF/ID. Reset wins, then stall, then redirect/sequential.
    always_ff @(posedge clk) begin
        if (reset) begin
            PC             <= RESET_PC;
            Instruction_id <= 32'h0;
            NextPC_id      <= 32'h0;
            FetchCount     <= 32'h0;
        end else if (PC_IFWrite) begin
            PC <= next_pc_aligned;
            if (IF_flush) begin
                Instruction_id <= 32'h0;
                NextPC_id      <= 32'h0;
            end else begin
                Instruction_id <= imem_data;
                NextPC_id      <= NextPC_if;
                FetchCount     <= FetchCount + 32'd1;
            end
        end
    end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 The clock port SHALL be named clk and the reset port SHALL be named reset.
REQ-003 Parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset.
REQ-004 Parameter IMEM_AW, default 6: instruction-memory word-address width.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 reset  input  1  synchronous active-high reset.
REQ-007 Z  input  1  branch taken, resolved in ID.
REQ-008 J  input  1  jump, resolved in ID.
REQ-009 JR  input  1  jump-register, resolved in ID.
REQ-010 PC_IFWrite  input  1  1 = advance PC and IF/ID register; 0 = stall.
REQ-011 JumpAddr  input  32  J target.
REQ-012 JrAddr  input  32  JR target.
REQ-013 BranchAddr  input  32  branch target.
REQ-014 imem_addr  output  IMEM_AW  word address to the combinational instruction ROM.
REQ-015 imem_data  input  32  instruction word returned by the ROM in the same cycle.
REQ-016 PC  output  32  current fetch PC.
REQ-017 NextPC_if  output  32  PC+4 of the instruction being fetched.
REQ-018 Instruction_id  output  32  IF/ID registered instruction.
REQ-019 NextPC_id  output  32  IF/ID registered PC+4.
REQ-020 IF_flush  output  1  combinational Z|J|JR.
REQ-021 FetchCount  output  32  count of instructions delivered into ID (not flushed).

Function
REQ-022 imem_addr SHALL equal PC[IMEM_AW+1:2].
REQ-023 Higher PC bits SHALL be ignored for ROM addressing, so addresses alias modulo 2^IMEM_AW words.
REQ-024 NextPC_if SHALL equal PC+4, computed modulo 2^32 so that 32'hFFFF_FFFC wraps to 0.
REQ-025 Next-PC selection SHALL use priority JR > J > Z > NextPC_if, selecting JrAddr, JumpAddr, BranchAddr or NextPC_if respectively.
REQ-026 Bits [1:0] of the selected next-PC value SHALL be forced to 2'b00 before it is loaded.
REQ-027 When PC_IFWrite=1, PC SHALL load the selected next-PC value on the rising edge.
REQ-028 When PC_IFWrite=0, PC SHALL hold.
REQ-029 IF_flush SHALL equal Z|J|JR combinationally, independent of PC_IFWrite.
REQ-030 When PC_IFWrite=1 and IF_flush=0, the IF/ID register SHALL load Instruction_id<=imem_data and NextPC_id<=NextPC_if.
REQ-031 When PC_IFWrite=1 and IF_flush=1, the IF/ID register SHALL load Instruction_id<=32'h0 (nop) and NextPC_id<=32'h0.
REQ-032 When PC_IFWrite=0, the PC and the IF/ID register SHALL hold, even if Z/J/JR are asserted (stall dominates; the hazard unit re-presents the redirect after the stall).
REQ-033 FetchCount SHALL increment by 1 on each edge where PC_IFWrite=1 and IF_flush=0.
REQ-034 FetchCount SHALL wrap from 32'hFFFF_FFFF to 0.
REQ-035 The block SHALL have a fetch-to-ID latency of exactly one cycle.
REQ-036 A redirect SHALL cost exactly one bubble: the flushed slot plus the fetch at the target on the next edge.

Reset
REQ-037 While reset=1 at a rising edge, the block SHALL load PC<=RESET_PC, Instruction_id<=0, NextPC_id<=0 and FetchCount<=0.
REQ-038 Reset SHALL override stall and redirect inputs.
REQ-039 Assertion of reset mid-stall or mid-redirect SHALL discard any pending state.
REQ-040 Fetch SHALL resume from RESET_PC on the first edge after reset deasserts.

Verification
REQ-041 Sequential fetch: reset, then PC_IFWrite=1 for 3 cycles with ROM[0..2]=A,B,C -> PC goes 0,4,8,12; Instruction_id goes A,B,C; NextPC_id goes 4,8,12; FetchCount=3.
REQ-042 Stall: with PC=8, hold PC_IFWrite=0 for 2 cycles -> PC=8 and Instruction_id unchanged for both cycles; FetchCount unchanged.
REQ-043 Priority: with PC=8, set Z=J=JR=1, JrAddr=0x40, JumpAddr=0x80, BranchAddr=0xC0 -> PC=0x40 next cycle; Instruction_id=0; FetchCount unchanged.
REQ-044 Stall dominates redirect: PC_IFWrite=0 with J=1 and JumpAddr=0x20 -> PC holds; IF/ID holds; IF_flush=1 combinationally.
REQ-045 Alignment and wrap: set BranchAddr=0x13 with Z=1 -> PC=0x10; set PC=0xFFFF_FFFC and advance -> PC=0; imem_addr=0 with IMEM_AW=6.
REQ-046 Reset mid-operation: with PC=0x40, FetchCount=5 and a stall active, assert reset for 1 cycle -> PC=RESET_PC, Instruction_id=0, NextPC_id=0, FetchCount=0.
